// File: rtl/bit_serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: a single full-adder cell walks the
// operands LSB first, one bit per clock, with the carry held in a register.
module bit_serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               carry_reg, carry_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               co_reg, co_next;
    logic               ovf_reg, ovf_next;
    logic               zero_reg, zero_next;
    logic               done_reg, done_next;

    // Subtraction is A + ~B + 1: invert B here, the +1 enters as the initial carry.
    logic [WIDTH-1:0]   b_eff;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_b_inv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    logic fa_s;
    logic fa_c;
    assign fa_s = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign fa_c = (a_sh_reg[0] & b_sh_reg[0]) |
                  (a_sh_reg[0] & carry_reg)   |
                  (b_sh_reg[0] & carry_reg);

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        sum_next    = sum_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        co_next     = co_reg;
        ovf_next    = ovf_reg;
        zero_next   = zero_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b_eff;
                    carry_next = sub;
                    cnt_next   = '0;
                    sum_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                carry_next = fa_c;
                sum_next   = {fa_s, sum_reg[WIDTH-1:1]};
                a_sh_next  = a_sh_reg >> 1;
                b_sh_next  = b_sh_reg >> 1;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    // Sign bits are in the LSB positions during the MSB cycle.
                    ovf_next   = (a_sh_reg[0] == b_sh_reg[0]) && (fa_s != a_sh_reg[0]);
                    cnt_next   = '0;
                    state_next = FIN;
                end
            end
            FIN: begin
                result_next = sum_reg;
                co_next     = carry_reg;
                zero_next   = (sum_reg == '0);
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            co_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            sum_reg    <= sum_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            co_reg     <= co_next;
            ovf_reg    <= ovf_next;
            zero_reg   <= zero_next;
            done_reg   <= done_next;
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = done_reg;
    assign result = result_reg;
    assign co     = co_reg;
    assign ovf    = ovf_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Directed bench for bit_serial_addsub: expected results come from a reference
// model pushed into a scoreboard queue at START and popped at DONE.
module tb_bit_serial_addsub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         co;
    logic         ovf;
    logic         zero;

    bit_serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .co     (co),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ovf;
        logic         zero;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] last_res = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input string name);
        exp_t         e;
        logic [W-1:0] y_eff;
        logic [W:0]   full;
        y_eff  = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, s};
        e.res  = full[W-1:0];
        e.co   = full[W];
        e.ovf  = (x[W-1] == y_eff[W-1]) && (full[W-1] != x[W-1]);
        e.zero = (full[W-1:0] == '0);
        e.name = name;
        return e;
    endfunction

    // Called at a negedge; drives one START pulse and follows the operation to DONE.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input string name, input bit disturb);
        int   lat;
        int   busy_cnt;
        int   extra_done;
        exp_t e;
        a = x; b = y; sub = s; start = 1'b1;
        sb_q.push_back(model(x, y, s, name));
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (disturb && lat == 4) begin
                a = $urandom; b = $urandom; sub = ~s; start = 1'b1;
            end
            if (disturb && lat == 5) start = 1'b0;
            if (lat == 10) check({name, "_hold"}, result, last_res);
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, W'(lat), W'(W + 1));
        check({name, "_busy_cycles"}, W'(busy_cnt), W'(W));
        check({name, "_busy_at_done"}, W'(busy), W'(0));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_co"}, W'(co), W'(e.co));
            check({e.name, "_ovf"}, W'(ovf), W'(e.ovf));
            check({e.name, "_zero"}, W'(zero), W'(e.zero));
            last_res = e.res;
            $display("op %s a=%08h b=%08h sub=%0d -> result=%08h co=%0d ovf=%0d zero=%0d",
                     e.name, x, y, s, result, co, ovf, zero);
        end
        @(negedge clk);
        check({name, "_done_width"}, W'(done), W'(0));
        if (disturb) begin
            extra_done = 0;
            for (int i = 0; i < W + 4; i++) begin
                if (done || busy) extra_done++;
                @(negedge clk);
            end
            check({name, "_no_second_op"}, W'(extra_done), W'(0));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; sub = 1'b0; a = 32'd1; b = 32'd1;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, '0);
        check("rst_flags", W'({co, ovf, zero}), W'(0));
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        run_op(32'd5, 32'd3, 1'b0, "add_5_3", 1'b0);
        run_op(32'd5, 32'd5, 1'b1, "sub_5_5", 1'b0);
        run_op(32'd3, 32'd5, 1'b1, "sub_3_5", 1'b0);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, "add_ovf", 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b1, "sub_ovf", 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "add_wrap", 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "add_negovf", 1'b0);
        run_op(32'd10, 32'd20, 1'b0, "isolate", 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_op($urandom, $urandom, k[0], $sformatf("rand%0d", k), 1'b0);
        end

        // Abort an operation partway through RUN.
        a = 32'h0000_FFFF; b = 32'd1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_result", result, '0);
        check("abort_flags", W'({co, ovf, zero}), W'(0));
        $display("op abort result=%08h busy=%0d done=%0d", result, busy, done);
        @(negedge clk);
        rst = 1'b1;
        last_res = '0;
        run_op(32'd7, 32'd8, 1'b0, "after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
